// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: rotated MSB-first search, registered grant held until release.
// Optional macro ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced revoke with per-requester masking.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_cfg_err
    $error("rr_arbiter8: MAX_HOLD must be 2..255 and below 2**CNT_W");
  end

  // HOLDOFF is the arbitrating idle cycle that follows a forced revoke
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HOLDOFF = 2'd2} state_t;

  state_t     state_p0, state_nxt;
  logic [2:0] owner_p0, owner_nxt;
  logic [2:0] last_p0, last_nxt;
  logic [2:0] winner;
  logic [7:0] eff;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       mask_p0, mask_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  assign eff = req & ~mask_p0;
`else
  assign eff = req;
`endif

  // Rotated search: last-1 is checked last in the loop so it wins; last itself is lowest.
  always_comb begin
    logic [2:0] idx;
    winner = '0;
    idx    = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = last_p0 - 3'(k);
      if (eff[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      owner_p0 <= '0;
      last_p0  <= '0;
`ifdef ARB_TIMEOUT_EN
      mask_p0  <= '0;
      cnt_p0   <= '0;
`endif
    end else begin
      state_p0 <= state_nxt;
      owner_p0 <= owner_nxt;
      last_p0  <= last_nxt;
`ifdef ARB_TIMEOUT_EN
      mask_p0  <= mask_nxt;
      cnt_p0   <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_p0;
    owner_nxt = owner_p0;
    last_nxt  = last_p0;
`ifdef ARB_TIMEOUT_EN
    mask_nxt  = mask_p0 & req;
    cnt_nxt   = cnt_p0;
`endif
    case (state_p0)
      GRANT: begin
        if (!req[owner_p0]) begin
          state_nxt = IDLE;
          last_nxt  = owner_p0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_p0 == CNT_W'(MAX_HOLD - 1)) begin
          state_nxt          = HOLDOFF;
          last_nxt           = owner_p0;
          mask_nxt[owner_p0] = 1'b1;
        end else begin
          cnt_nxt = cnt_p0 + 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        if (|eff) begin
          state_nxt = GRANT;
          owner_nxt = winner;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
    endcase
  end

  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    timeout     = 1'b0;
    if (state_p0 == GRANT) begin
      grant[owner_p0] = 1'b1;
      grant_id        = owner_p0;
      grant_valid     = 1'b1;
    end
`ifdef ARB_TIMEOUT_EN
    timeout = (state_p0 == HOLDOFF);
`endif
  end

endmodule
